// File: rtl/pacman_referee.sv
// pacman_referee: game-status stage downstream of the playfield.
// Tracks score (candies eaten while in PLAY), lives and ghost collisions, and
// decodes the game outcome flags (respawn / lost / won) from registered state.
// Optional build macro PACMAN_REFEREE_SWAP_DETECT_EN: when defined, a sprite
// crossing (both sprites swap cells on one edge) also counts as a collision.
// No handshake here: every input is sampled on every rising edge; outputs are
// registered (or decoded from registered state), so latency is one cycle.
module pacman_referee #(
  parameter int WIDTH          = 8,
  parameter int HEIGHT         = 8,
  parameter int LIVES          = 3,
  parameter int RESPAWN_CYCLES = 4,
  parameter int SCORE_W        = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WIDTH-1:0]          pacman_x,
  input  logic [HEIGHT-1:0]         pacman_y,
  input  logic [WIDTH-1:0]          ghost_x,
  input  logic [HEIGHT-1:0]         ghost_y,
  input  logic [WIDTH*HEIGHT-1:0]   candies,
  output logic [2:0]                state,
  output logic [SCORE_W-1:0]        score,
  output logic [2:0]                lives,
  output logic                      hit,
  output logic                      respawn,
  output logic                      lost,
  output logic                      won
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_HIT  = 3'd2,
    ST_LOST = 3'd3,
    ST_WON  = 3'd4
  } state_t;

  localparam int N_CELLS = WIDTH * HEIGHT;
  localparam int CNT_W   = $clog2(N_CELLS + 1);
  localparam int SUM_W   = ((SCORE_W > CNT_W) ? SCORE_W : CNT_W) + 1;

  localparam logic [SCORE_W-1:0] SCORE_MAX    = '1;
  localparam logic [2:0]         LIVES_INIT   = 3'(LIVES);
  localparam logic [3:0]         RESPAWN_LOAD = 4'(RESPAWN_CYCLES - 1);

  state_t                  st;
  logic [N_CELLS-1:0]      prev_candies;
  logic [3:0]              hit_cnt;
  logic [N_CELLS-1:0]      eaten_bits;
  logic [CNT_W-1:0]        eaten;
  logic [SUM_W-1:0]        score_sum;
  logic [SCORE_W-1:0]      score_next;
  logic                    exact_hit;
  logic                    collision;

  assign state   = st;
  assign respawn = (st == ST_HIT);
  assign lost    = (st == ST_LOST);
  assign won     = (st == ST_WON);

  // A candy is eaten when its bit falls from 1 to 0 between samples.
  assign eaten_bits = prev_candies & ~candies;

  // Population count of the candies that disappeared this cycle.
  always_comb begin
    eaten = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      eaten = eaten + CNT_W'(eaten_bits[i]);
    end
  end

  // Saturating add: a wide sum is clamped to the all-ones score.
  assign score_sum  = SUM_W'(score) + SUM_W'(eaten);
  assign score_next = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX
                                                      : score_sum[SCORE_W-1:0];

  assign exact_hit = (pacman_x == ghost_x) && (pacman_y == ghost_y);

`ifdef PACMAN_REFEREE_SWAP_DETECT_EN
  logic [WIDTH-1:0]  prev_pacman_x;
  logic [HEIGHT-1:0] prev_pacman_y;
  logic [WIDTH-1:0]  prev_ghost_x;
  logic [HEIGHT-1:0] prev_ghost_y;
  logic              swap_hit;

  // Remember last cycle's sprite cells so a crossing can be recognised.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pacman_x <= '0;
      prev_pacman_y <= '0;
      prev_ghost_x  <= '0;
      prev_ghost_y  <= '0;
    end else begin
      prev_pacman_x <= pacman_x;
      prev_pacman_y <= pacman_y;
      prev_ghost_x  <= ghost_x;
      prev_ghost_y  <= ghost_y;
    end
  end

  assign swap_hit  = (pacman_x == prev_ghost_x) && (pacman_y == prev_ghost_y) &&
                     (ghost_x == prev_pacman_x) && (ghost_y == prev_pacman_y);
  assign collision = exact_hit | swap_hit;
`else
  assign collision = exact_hit;
`endif

  // Game FSM with registered score, lives and hit pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= ST_IDLE;
      score        <= '0;
      lives        <= LIVES_INIT;
      hit          <= 1'b0;
      hit_cnt      <= '0;
      prev_candies <= '0;
    end else begin
      prev_candies <= candies;
      hit          <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (start) st <= ST_PLAY;
        end
        ST_PLAY: begin
          score <= score_next;
          if (candies == '0) begin
            // Clearing the board wins even if the ghost catches Pac-Man now.
            st <= ST_WON;
          end else if (collision) begin
            hit <= 1'b1;
            if (lives > 3'd1) begin
              lives   <= lives - 3'd1;
              hit_cnt <= RESPAWN_LOAD;
              st      <= ST_HIT;
            end else begin
              lives <= 3'd0;
              st    <= ST_LOST;
            end
          end
        end
        ST_HIT: begin
          if (hit_cnt == 4'd0) begin
            st <= ST_PLAY;
          end else begin
            hit_cnt <= hit_cnt - 4'd1;
          end
        end
        ST_LOST: st <= ST_LOST;
        ST_WON:  st <= ST_WON;
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pacman_referee.sv
// tb_pacman_referee: vector table plus hand sequences plus random stimulus,
// all checked against a rule-level game model. A second instance with a
// 3-bit score exercises saturation on the same stimulus.
module tb_pacman_referee;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  pacman_x, pacman_y, ghost_x, ghost_y;
  logic [63:0] candies;

  logic [2:0]  state, lives;
  logic [15:0] score;
  logic        hit, respawn, lost, won;

  logic [2:0]  state_s, lives_s;
  logic [2:0]  score_s;
  logic        hit_s, respawn_s, lost_s, won_s;

  int total = 0;
  int bad   = 0;

  // expected main score per checked cycle
  logic [15:0] exp_q[$];

  pacman_referee dut (
    .clk(clk), .reset(reset), .start(start),
    .pacman_x(pacman_x), .pacman_y(pacman_y),
    .ghost_x(ghost_x), .ghost_y(ghost_y), .candies(candies),
    .state(state), .score(score), .lives(lives), .hit(hit),
    .respawn(respawn), .lost(lost), .won(won)
  );

  pacman_referee #(.SCORE_W(3)) dut_s (
    .clk(clk), .reset(reset), .start(start),
    .pacman_x(pacman_x), .pacman_y(pacman_y),
    .ghost_x(ghost_x), .ghost_y(ghost_y), .candies(candies),
    .state(state_s), .score(score_s), .lives(lives_s), .hit(hit_s),
    .respawn(respawn_s), .lost(lost_s), .won(won_s)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (game rules) ----------------
  int          m_state;   // 0 idle 1 play 2 hit 3 lost 4 won
  int          m_score, m_score3, m_lives, m_hit, m_hit_left;
  logic [63:0] m_prevc;
  int          m_ppx, m_ppy, m_pgx, m_pgy;

  task automatic model_step(input logic rst, input logic st_in,
                            input int px, input int py, input int gx, input int gy,
                            input logic [63:0] c);
    int  eat;
    bit  coll;
    if (rst) begin
      m_state = 0; m_score = 0; m_score3 = 0; m_lives = 3; m_hit = 0;
      m_hit_left = 0; m_prevc = '0;
      m_ppx = 0; m_ppy = 0; m_pgx = 0; m_pgy = 0;
    end else begin
      eat   = $countones(m_prevc & ~c);
      coll  = (px == gx) && (py == gy);
`ifdef PACMAN_REFEREE_SWAP_DETECT_EN
      coll  = coll || ((px == m_pgx) && (py == m_pgy) && (gx == m_ppx) && (gy == m_ppy));
`endif
      m_hit = 0;
      case (m_state)
        0: if (st_in) m_state = 1;
        1: begin
          m_score  = (m_score + eat > 65535) ? 65535 : m_score + eat;
          m_score3 = (m_score3 + eat > 7) ? 7 : m_score3 + eat;
          if (c == 64'd0) m_state = 4;
          else if (coll) begin
            m_hit = 1;
            if (m_lives > 1) begin
              m_lives    = m_lives - 1;
              m_hit_left = 4;
              m_state    = 2;
            end else begin
              m_lives = 0;
              m_state = 3;
            end
          end
        end
        2: begin
          m_hit_left = m_hit_left - 1;
          if (m_hit_left == 0) m_state = 1;
        end
        default: ;
      endcase
      m_prevc = c;
      m_ppx = px; m_ppy = py; m_pgx = gx; m_pgy = gy;
    end
    exp_q.push_back(16'(m_score));
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("score", 32'(score), 32'(e));
    end
    chk("state",    32'(state),     32'(m_state));
    chk("lives",    32'(lives),     32'(m_lives));
    chk("hit",      32'(hit),       32'(m_hit));
    chk("respawn",  32'(respawn),   32'(m_state == 2));
    chk("lost",     32'(lost),      32'(m_state == 3));
    chk("won",      32'(won),       32'(m_state == 4));
    chk("score_s",  32'(score_s),   32'(m_score3));
    chk("state_s",  32'(state_s),   32'(m_state));
    chk("lives_s",  32'(lives_s),   32'(m_lives));
    chk("hit_s",    32'(hit_s),     32'(m_hit));
    chk("flags_s",  32'({respawn_s, lost_s, won_s}),
        32'({m_state == 2, m_state == 3, m_state == 4}));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic rst, input logic st_in,
                       input int px, input int py, input int gx, input int gy,
                       input logic [63:0] c);
    reset    = rst;
    start    = st_in;
    pacman_x = 8'(px); pacman_y = 8'(py);
    ghost_x  = 8'(gx); ghost_y  = 8'(gy);
    candies  = c;
    model_step(rst, st_in, px, py, gx, gy, c);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        st;
    int          px, py, gx, gy;
    logic [63:0] c;
    int          e_state, e_score, e_lives, e_hit;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic st_in, input int px, input int py,
                              input int gx, input int gy, input logic [63:0] c,
                              input int es, input int esc, input int el, input int eh);
    vec_t v;
    v.st = st_in; v.px = px; v.py = py; v.gx = gx; v.gy = gy; v.c = c;
    v.e_state = es; v.e_score = esc; v.e_lives = el; v.e_hit = eh;
    return v;
  endfunction

  initial begin
    logic [63:0] cm;
    logic [63:0] cur_c;
    int          term_cycles;

    reset = 1'b1; start = 1'b0;
    pacman_x = '0; pacman_y = '0; ghost_x = '0; ghost_y = '0; candies = '0;

    cm = '1;
    tbl[0] = mk(1, 1, 1, 6, 6, cm, 1, 0, 3, 0);
    for (int i = 1; i <= 5; i++) begin
      cm[i-1] = 1'b0;
      tbl[i] = mk(0, 1, 1, 6, 6, cm, 1, i, 3, 0);
    end
    cm[5] = 1'b0; cm[6] = 1'b0;
    tbl[6]  = mk(0, 1, 1, 6, 6, cm, 1, 7, 3, 0);
    tbl[7]  = mk(0, 3, 2, 3, 2, cm, 2, 7, 2, 1);
    cm[7] = 1'b0;   // eaten during HIT: never scored
    tbl[8]  = mk(0, 1, 1, 6, 6, cm, 2, 7, 2, 0);
    tbl[9]  = mk(0, 1, 1, 6, 6, cm, 2, 7, 2, 0);
    tbl[10] = mk(0, 3, 2, 3, 2, cm, 2, 7, 2, 0);
    tbl[11] = mk(0, 3, 2, 3, 2, cm, 1, 7, 2, 0);
    tbl[12] = mk(0, 3, 2, 3, 2, cm, 2, 7, 1, 1);
    tbl[13] = mk(0, 3, 2, 3, 2, cm, 2, 7, 1, 0);
    tbl[14] = mk(0, 3, 2, 3, 2, cm, 2, 7, 1, 0);
    tbl[15] = mk(0, 3, 2, 3, 2, cm, 2, 7, 1, 0);
    tbl[16] = mk(0, 3, 2, 3, 2, cm, 1, 7, 1, 0);
    tbl[17] = mk(0, 3, 2, 3, 2, cm, 3, 7, 0, 1);
    tbl[18] = mk(1, 3, 2, 3, 2, cm, 3, 7, 0, 0);
    tbl[19] = mk(1, 3, 2, 3, 2, 64'd0, 3, 7, 0, 0);

    // reset state
    cycle(1, 0, 0, 0, 0, 0, '1);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_lives", 32'(lives), 32'd3);

    for (int i = 0; i < 20; i++) begin
      cycle(0, tbl[i].st, tbl[i].px, tbl[i].py, tbl[i].gx, tbl[i].gy, tbl[i].c);
      chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].e_state));
      chk($sformatf("tbl%0d_score", i), 32'(score), 32'(tbl[i].e_score));
      chk($sformatf("tbl%0d_lives", i), 32'(lives), 32'(tbl[i].e_lives));
      chk($sformatf("tbl%0d_hit", i),   32'(hit),   32'(tbl[i].e_hit));
    end

    // reset out of LOST
    cycle(1, 0, 1, 1, 6, 6, '1);
    chk("relost_state", 32'(state), 32'd0);
    chk("relost_lives", 32'(lives), 32'd3);

    // last candy cleared together with a collision: win, no hit
    cycle(0, 1, 1, 1, 6, 6, '1);
    cycle(0, 0, 3, 2, 3, 2, 64'd0);
    chk("win_won",   32'(won),   32'd1);
    chk("win_lives", 32'(lives), 32'd3);
    chk("win_hit",   32'(hit),   32'd0);
    chk("win_score", 32'(score), 32'd64);
    chk("win_sat3",  32'(score_s), 32'd7);

    // sprite crossing
    cycle(1, 0, 0, 0, 0, 0, '1);
    cycle(0, 1, 2, 1, 3, 1, '1);
    cycle(0, 0, 2, 1, 3, 1, '1);
    cycle(0, 0, 3, 1, 2, 1, '1);
`ifdef PACMAN_REFEREE_SWAP_DETECT_EN
    chk("swap_hit",   32'(hit),   32'd1);
    chk("swap_lives", 32'(lives), 32'd2);
`else
    chk("swap_hit",   32'(hit),   32'd0);
    chk("swap_lives", 32'(lives), 32'd3);
`endif

    // randomized play against the model
    cur_c = '1;
    term_cycles = 0;
    cycle(1, 0, 0, 0, 0, 0, cur_c);
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic rst_now;
      r = $urandom_range(0, 99);
      if (r < 2) cur_c = 64'd0;
      else if (r < 6) cur_c = {$urandom, $urandom};
      else begin
        cur_c[$urandom_range(0, 63)] = 1'b0;
        if ($urandom_range(0, 1) == 1) cur_c[$urandom_range(0, 63)] = 1'b0;
      end
      if (m_state >= 3) term_cycles++;
      rst_now = (term_cycles > 6) || ($urandom_range(0, 199) == 0);
      if (rst_now) begin
        term_cycles = 0;
        cur_c = '1;
      end
      cycle(rst_now, ($urandom_range(0, 3) == 0),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), cur_c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pacman_referee.md
# pacman_referee

Game-status stage that sits directly downstream of the Pac-Man playfield block. It samples Pac-Man and ghost positions and the candy map every cycle. From these it keeps the score and the lives count, and it detects pacman/ghost collisions. It drives the game-level outcome flags (`lost`, `won`) and a `respawn` request back toward the playfield and the display logic.

## Interface
Parameters:
- `WIDTH`, 8, grid width; also the bit width of X positions.
- `HEIGHT`, 8, grid height; also the bit width of Y positions.
- `LIVES`, 3, lives at game start (1..7).
- `RESPAWN_CYCLES`, 4, number of cycles spent in HIT (1..15).
- `SCORE_W`, 16, score counter width.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous active-high reset.
- `start`  in  1  level; leaves IDLE.
- `pacman_x`  in  WIDTH  Pac-Man X.
- `pacman_y`  in  HEIGHT  Pac-Man Y.
- `ghost_x`  in  WIDTH  ghost X.
- `ghost_y`  in  HEIGHT  ghost Y.
- `candies`  in  WIDTH*HEIGHT  packed candy map; bit x*HEIGHT+y = candy at (x,y).
- `state`  out  3  IDLE=0, PLAY=1, HIT=2, LOST=3, WON=4.
- `score`  out  SCORE_W  candies eaten, saturating.
- `lives`  out  3  remaining lives.
- `hit`  out  1  one-cycle pulse on a collision.
- `respawn`  out  1  high for the whole HIT state; the playfield returns its sprites to their start cells.
- `lost`  out  1  high in LOST.
- `won`  out  1  high in WON.

## Operation
- Reset values: `state`=IDLE, `score`=0, `lives`=LIVES, `hit`=0, `respawn`=0, `lost`=0, `won`=0. Internal `prev_candies` and the HIT counter are also cleared to 0.
- `prev_candies` <= `candies` every cycle, in every state.
- Eaten count: eaten = popcount(prev_candies & ~candies).
  - In PLAY, score <= min(score + eaten, 2^SCORE_W−1).
  - In all other states, score holds.
- Collision condition: pacman_x==ghost_x && pacman_y==ghost_y.
- IDLE → PLAY when `start`=1. Otherwise the block holds in IDLE.
- PLAY, with these priorities:
  1. If `candies`==0: go to WON. This takes priority over a collision in the same cycle.
  2. Else, if a collision occurs and lives>1: lives−1, pulse `hit`, go to HIT with the counter loaded to RESPAWN_CYCLES−1.
  3. Else, if a collision occurs and lives==1: lives=0, pulse `hit`, go to LOST.
- HIT:
  - `respawn`=1 for the whole state.
  - Collisions and eaten candies are ignored.
  - The counter decrements each cycle. When it is 0, go to PLAY.
- LOST and WON are terminal. They hold until `reset`, and `start` is ignored.
- `reset` asserted in any state overrides all other logic on that edge.

## Timing
- Inputs sampled at edge N → `state`, `lives`, `score` and `hit` update at edge N+1. Latency is 1 cycle and there is no combinational input→output path.
- `respawn`, `lost` and `won` are decoded from registered `state`, so they are glitch-free.
- HIT lasts exactly RESPAWN_CYCLES cycles. `state`=PLAY on the cycle after the last `respawn`=1 cycle.
- Collision detection resumes on the first PLAY cycle after HIT, so a sprite overlap still present then counts as a new hit.
- A candy eaten on the same edge as the IDLE→PLAY transition is not scored, because scoring applies only while already in PLAY.

## Configuration
- Macro: `PACMAN_REFEREE_SWAP_DETECT_EN`.
- Defined: a crossing also counts as a collision. A crossing is when Pac-Man's current cell equals the ghost's previous cell and the ghost's current cell equals Pac-Man's previous cell. This adds registered copies of both previous positions, cleared on reset and updated every cycle.
- Undefined: only the exact equal-cell condition counts, and the previous-position registers are not built.

## Test plan
- Reset, then `start`=1 with pacman (1,1), ghost (6,6) and the candy map unchanged → `state`=PLAY after 1 edge; `score`=0, `lives`=3.
- In PLAY, clear candy bits one per cycle for 5 cycles → `score`=5. Clear 2 bits in one cycle → `score`+2. Set SCORE_W=3 and eat 9 candies → `score`=7 (saturated).
- In PLAY, drive pacman=ghost=(3,2) → next cycle `hit`=1 for one cycle, `lives`=2, `respawn`=1 for exactly 4 cycles, then `state`=PLAY.
- Three collisions separated by respawns → after the third, `lives`=0, `lost`=1, `state`=LOST. Holding `start`=1 and further collisions leave it LOST. `reset` returns `lives`=3 and `state`=IDLE.
- Last candy cleared on the same cycle as a collision → `won`=1, `lives` unchanged, `hit`=0.
- Swap: pacman (2,1)→(3,1) while ghost (3,1)→(2,1). With the macro defined → `hit`=1 and `lives` decrements. Without it → no hit.
